apb_cfg_master: RTL and testbench

- APB initiator that converts single register-access commands into APB SETUP/ACCESS transfers.
- Returns read data and error status through a response handshake.
- Sits between the testbench/firmware command path and the MCDF register slave (8-bit address, 32-bit data APB).
- Adds a bounded wait on pready so that a hung slave cannot stall the command path.

---
 rtl/apb_cfg_master.sv | 197 +++++++++++++++++++
 tb/tb_apb_cfg_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master.sv
// ---------------------------------------------------------------------------
// apb_cfg_master
//
// Turns single register-access commands into one APB SETUP/ACCESS transfer
// each and hands back read data plus error/timeout status through a response
// handshake. Intended to sit between the command path and the MCDF register
// slave (8-bit address, 32-bit data). A bounded wait on pready keeps a hung
// slave from stalling the command path forever.
//
// Handshakes (both channels): a transfer happens on a rising clk_i edge where
// valid && ready are both 1. A producer holds valid and its payload stable
// until that edge; ready may change freely and never depends on valid in the
// same cycle here.
//
// Parameters
//   TIMEOUT_CYC : ACCESS cycles with pready low before the transfer is
//                 aborted; 0 disables the timeout.
//   CNT_W       : wait counter width, 2**CNT_W > TIMEOUT_CYC.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_wr_i/addr_i/wdata_i   command payload (1 = write)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o               read data (0 for writes and timeouts)
//   rsp_err_o                 pslverr or timeout
//   rsp_timeout_o             transfer aborted by timeout
//   paddr_o..pwdata_o         registered APB request outputs
//   prdata_i/pready_i/pslverr_i APB completion inputs
//   dbg_state_o               current FSM state (IDLE=0 SETUP=1 ACCESS=2 RESP=3)
// ---------------------------------------------------------------------------
module apb_cfg_master #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [7:0]  paddr_o,
  output logic        pwr_o,
  output logic        psel_o,
  output logic        pen_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter is compared one bit wider so cnt+1 never wraps before the match.
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W+1)'(TIMEOUT_CYC);
  localparam bit             TO_EN    = (TIMEOUT_CYC != 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;

  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwr_q, pwr_d;
  logic [7:0]        paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Ready is purely a function of state (and held low during reset).
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;

  assign psel_o        = psel_q;
  assign pen_o         = pen_q;
  assign pwr_o         = pwr_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    pen_d         = pen_q;
    pwr_d         = pwr_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          pwr_d    = cmd_wr_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        // pready is checked first so a completion on the last allowed
        // cycle is never reported as a timeout.
        if (pready_i) begin
          psel_d        = 1'b0;
          pen_d         = 1'b0;
          rsp_rdata_d   = pwr_q ? 32'h0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (TO_EN && (cnt_inc == TO_LIMIT)) begin
            psel_d        = 1'b0;
            pen_d         = 1'b0;
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      pen_q         <= 1'b0;
      pwr_q         <= 1'b0;
      paddr_q       <= 8'h0;
      pwdata_q      <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      pen_q         <= pen_d;
      pwr_q         <= pwr_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cfg_master
//
// Directed bench for apb_cfg_master (TIMEOUT_CYC=16). A small APB slave
// model with a 64-word register file sits on the bus; its wait states,
// error response and hang behaviour are steered by the test tasks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_cfg_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = 8'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        pwr, psel, pen;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  apb_cfg_master #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_wr_i     (cmd_wr),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pwr_o        (pwr),
    .psel_o       (psel),
    .pen_o        (pen),
    .pwdata_o     (pwdata),
    .prdata_i     (prdata),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- APB slave model ----------------
  logic [31:0] mem [64];
  int          slv_wait = 0;   // pready low for this many ACCESS cycles
  logic        slv_err  = 1'b0;
  logic        slv_hang = 1'b0;
  int          acc_cnt  = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[2] = 32'h0302_0100;
  end

  assign pready  = psel && pen && !slv_hang && (acc_cnt >= slv_wait);
  assign pslverr = pready && slv_err;
  assign prdata  = mem[paddr[7:2]];

  always @(posedge clk) begin
    if (psel && pen && !pready) acc_cnt <= acc_cnt + 1;
    else                        acc_cnt <= 0;
    if (psel && pen && pready && pwr && !slv_err) mem[paddr[7:2]] <= pwdata;
  end

  // ---------------- ACCESS-phase monitor ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_cycles = 0;
  int          stable_bad = 0;
  logic [7:0]  mon_addr = 8'h0;
  logic [31:0] mon_wdata = 32'h0;
  logic        mon_wr = 1'b0;

  always @(negedge clk) begin
    if (psel && pen) begin
      acc_cycles = acc_cycles + 1;
      if (paddr !== mon_addr || pwdata !== mon_wdata || pwr !== mon_wr)
        stable_bad = stable_bad + 1;
    end
  end

  // ---------------- driver tasks (called at a falling edge, DUT idle) ----
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int lat);
    mon_addr = a; mon_wdata = d; mon_wr = wr;
    acc_cycles = 0; stable_bad = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_wait addr=%02h: no rsp_valid within %0d cycles", a, lat);
    end
    rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL reset_psel got=%b want=0", psel); end
    n_cmp++; if (pen !== 1'b0) begin n_bad++; $display("FAIL reset_pen got=%b want=0", pen); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    n_cmp++; if (paddr !== 8'h00 || pwdata !== 32'h0 || pwr !== 1'b0) begin
      n_bad++; $display("FAIL reset_apb_regs paddr=%02h pwdata=%08h pwr=%b want 0", paddr, pwdata, pwr); end
    n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      n_bad++; $display("FAIL reset_rsp_regs rdata=%08h err=%b to=%b want 0", rsp_rdata, rsp_err, rsp_timeout); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_read_after_reset();
    logic [31:0] rd; logic er, to; int lat;
    do_cmd(1'b0, 8'h08, 32'h0, rd, er, to, lat);
    n_cmp++; if (rd !== 32'h0302_0100) begin n_bad++; $display("FAIL rd08_data got=%08h want=03020100", rd); end
    n_cmp++; if (er !== 1'b0 || to !== 1'b0) begin n_bad++; $display("FAIL rd08_status err=%b to=%b want 0/0", er, to); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd08_latency got=%0d want=3", lat); end
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er, to; int lat;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h08; cmd_wdata = 32'h0706_0504;
    @(negedge clk);
    n_cmp++; if (psel !== 1'b1 || pen !== 1'b0) begin n_bad++; $display("FAIL wr_setup psel=%b pen=%b want 1/0", psel, pen); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL wr_setup_state got=%0d want=1", dbg_state); end
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (psel !== 1'b1 || pen !== 1'b1) begin n_bad++; $display("FAIL wr_access psel=%b pen=%b want 1/1", psel, pen); end
    n_cmp++; if (paddr !== 8'h08 || pwdata !== 32'h0706_0504 || pwr !== 1'b1) begin
      n_bad++; $display("FAIL wr_access_bus paddr=%02h pwdata=%08h pwr=%b want 08/07060504/1", paddr, pwdata, pwr); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
      n_bad++; $display("FAIL wr_rsp valid=%b err=%b rdata=%08h to=%b want 1/0/0/0", rsp_valid, rsp_err, rsp_rdata, rsp_timeout); end
    n_cmp++; if (psel !== 1'b0 || pen !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_bus psel=%b pen=%b want 0/0", psel, pen); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_drop got=%b want=0", rsp_valid); end
    n_cmp++; if (paddr !== 8'h08 || pwr !== 1'b1 || pwdata !== 32'h0706_0504) begin
      n_bad++; $display("FAIL wr_retain paddr=%02h pwr=%b pwdata=%08h", paddr, pwr, pwdata); end
    do_cmd(1'b0, 8'h08, 32'h0, rd, er, to, lat);
    n_cmp++; if (rd !== 32'h0706_0504 || er !== 1'b0) begin n_bad++; $display("FAIL wr_readback got=%08h err=%b want=07060504/0", rd, er); end
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic er, to; int lat;
    slv_err = 1'b1;
    do_cmd(1'b0, 8'h40, 32'h0, rd, er, to, lat);
    slv_err = 1'b0;
    n_cmp++; if (er !== 1'b1 || to !== 1'b0) begin n_bad++; $display("FAIL slverr_status err=%b to=%b want 1/0", er, to); end
    n_cmp++; if (rd !== 32'hC0DE_0010) begin n_bad++; $display("FAIL slverr_rdata got=%08h want=c0de0010", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er, to; int lat;
    slv_wait = 3;
    do_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, rd, er, to, lat);
    n_cmp++; if (acc_cycles !== 4) begin n_bad++; $display("FAIL wait3_access_cycles got=%0d want=4", acc_cycles); end
    n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL wait3_bus_stable unstable_cycles=%0d want=0", stable_bad); end
    n_cmp++; if (er !== 1'b0 || to !== 1'b0 || rd !== 32'h0 || lat !== 6) begin
      n_bad++; $display("FAIL wait3_rsp err=%b to=%b rdata=%08h lat=%0d want 0/0/0/6", er, to, rd, lat); end
    slv_wait = 0;
    do_cmd(1'b0, 8'h10, 32'h0, rd, er, to, lat);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wait3_readback got=%08h want=deadbeef", rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, to; int lat;
    slv_hang = 1'b1;
    do_cmd(1'b0, 8'h0C, 32'h0, rd, er, to, lat);
    slv_hang = 1'b0;
    n_cmp++; if (acc_cycles !== 16 || lat !== 18) begin
      n_bad++; $display("FAIL timeout_len access=%0d lat=%0d want 16/18", acc_cycles, lat); end
    n_cmp++; if (er !== 1'b1 || to !== 1'b1 || rd !== 32'h0) begin
      n_bad++; $display("FAIL timeout_rsp err=%b to=%b rdata=%08h want 1/1/0", er, to, rd); end
    slv_wait = 15;
    do_cmd(1'b0, 8'h0C, 32'h0, rd, er, to, lat);
    slv_wait = 0;
    n_cmp++; if (acc_cycles !== 16 || lat !== 18) begin
      n_bad++; $display("FAIL late_ready_len access=%0d lat=%0d want 16/18", acc_cycles, lat); end
    n_cmp++; if (er !== 1'b0 || to !== 1'b0 || rd !== 32'hC0DE_0003) begin
      n_bad++; $display("FAIL late_ready_rsp err=%b to=%b rdata=%08h want 0/0/c0de0003", er, to, rd); end
  endtask

  task automatic test_back_to_back();
    // Response backpressure with the next command already waiting.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h08; cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_wr = 1'b1; cmd_addr = 8'h14; cmd_wdata = 32'h1122_3344;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0706_0504 || rsp_err !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] valid=%b rdata=%08h err=%b", i, rsp_valid, rsp_rdata, rsp_err); end
      n_cmp++; if (cmd_ready !== 1'b0 || psel !== 1'b0) begin
        n_bad++; $display("FAIL bp_cmd_ready[%0d] ready=%b psel=%b want 0/0", i, cmd_ready, psel); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin
      n_bad++; $display("FAIL bp_after_rsp ready=%b valid=%b psel=%b want 1/0/0", cmd_ready, rsp_valid, psel); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (psel !== 1'b1 || pen !== 1'b0 || paddr !== 8'h14 || pwr !== 1'b1 || pwdata !== 32'h1122_3344) begin
      n_bad++; $display("FAIL bp_next_cmd psel=%b pen=%b paddr=%02h pwr=%b pwdata=%08h", psel, pen, paddr, pwr, pwdata); end
    wait_rsp();
    n_cmp++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL bp_next_rsp err=%b rdata=%08h want 0/0", rsp_err, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er, to; int lat;
    slv_hang = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h0C; cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (psel !== 1'b1 || pen !== 1'b1) begin n_bad++; $display("FAIL mid_pre psel=%b pen=%b want 1/1", psel, pen); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (psel !== 1'b0 || pen !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset psel=%b pen=%b valid=%b want 0/0/0", psel, pen, rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready got=%b want=0", cmd_ready); end
    rst = 1'b0;
    slv_hang = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp got=%b want=0", rsp_valid); end
    do_cmd(1'b0, 8'h14, 32'h0, rd, er, to, lat);
    n_cmp++; if (rd !== 32'h1122_3344 || er !== 1'b0 || to !== 1'b0 || lat !== 3) begin
      n_bad++; $display("FAIL mid_post_cmd rdata=%08h err=%b to=%b lat=%0d want 11223344/0/0/3", rd, er, to, lat); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_read_after_reset();
    test_write();
    test_slverr();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
